// File: rtl/score_counter_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : score_counter_display                                      |
// | Description : Banner score block. Keeps an N-digit saturating BCD score  |
// |               and a latched high score, blinks the score field for a     |
// |               fixed number of frames when the high score is beaten, and  |
// |               renders both fields as 7-segment glyphs into a registered  |
// |               3-bit pixel colour (black = no draw).                      |
// | Ports       : i_clk, i_rst_n (sync, active-low)                          |
// |               i_vpos/i_hpos  current pixel row/column                    |
// |               i_frame_tick   one pulse per frame (blink timing)          |
// |               i_inc/i_clear  score +1 / new game                         |
// |               o_score_bcd, o_high_bcd  BCD fields, units in [3:0]        |
// |               o_new_high     sticky "high score beaten this game"        |
// |               o_rgb          pixel colour, 1 clock after i_hpos/i_vpos   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module score_counter_display #(
  parameter int         NUM_DIGITS    = 3,
  parameter int         BANNER_HEIGHT = 32,
  parameter int         DIGIT_W       = 12,
  parameter int         DIGIT_H       = 28,
  parameter int         SEG_T         = 4,
  parameter int         DIGIT_GAP     = 4,
  parameter int         Y_OFFSET      = 2,
  parameter int         SCORE_X       = 590,
  parameter int         HIGH_X        = 8,
  parameter int         LEAD_BLANK    = 1,
  parameter int         BLINK_FRAMES  = 120,
  parameter int         BLINK_HALF    = 8,
  parameter logic [2:0] BANNER_COLOR  = 3'b000,
  parameter logic [2:0] SCORE_COLOR   = 3'b100,
  parameter logic [2:0] HIGH_COLOR    = 3'b110
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [9:0]              i_vpos,
  input  logic [9:0]              i_hpos,
  input  logic                    i_frame_tick,
  input  logic                    i_inc,
  input  logic                    i_clear,
  output logic [4*NUM_DIGITS-1:0] o_score_bcd,
  output logic [4*NUM_DIGITS-1:0] o_high_bcd,
  output logic                    o_new_high,
  output logic [2:0]              o_rgb
);

  localparam int          C_BW       = 4 * NUM_DIGITS;
  localparam int          C_PITCH    = DIGIT_W + DIGIT_GAP;
  localparam int          C_CNT_W    = $clog2(BLINK_FRAMES + 1);
  localparam int          C_HALF_W   = $clog2(BLINK_HALF + 1);
  localparam logic [11:0] C_SEG_T    = 12'(SEG_T);
  localparam logic [11:0] C_DIGIT_W  = 12'(DIGIT_W);
  localparam logic [11:0] C_DIGIT_H  = 12'(DIGIT_H);
  localparam logic [11:0] C_Y0       = 12'(Y_OFFSET);
  localparam logic [11:0] C_HALF_H   = 12'(DIGIT_H >> 1);
  localparam logic [11:0] C_MID_LO   = 12'((DIGIT_H - SEG_T) >> 1);
  localparam logic [11:0] C_MID_HI   = 12'((DIGIT_H + SEG_T) >> 1);
  localparam logic [11:0] C_BOT_Y    = 12'(DIGIT_H - SEG_T);
  localparam logic [11:0] C_RIGHT_X  = 12'(DIGIT_W - SEG_T);
  localparam logic [11:0] C_BANNER_H = 12'(BANNER_HEIGHT);

  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_BLINK   = 1'b1;

  // ---------------------------------------------------------------------
  // Score counter: ripple-carry BCD increment, saturating at all nines
  // ---------------------------------------------------------------------
  logic [C_BW-1:0] score_q, score_d;
  logic [C_BW-1:0] w_score_inc;
  logic            w_carry;
  logic            w_score_max;

  always_comb begin
    w_score_inc = score_q;
    w_carry     = 1'b1;
    w_score_max = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) w_score_max = 1'b0;
      if (w_carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          w_score_inc[4*i +: 4] = 4'd0;      // carry ripples on
        end else begin
          w_score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    score_d = score_q;
    if (i_clear)                    score_d = '0;
    else if (i_inc && !w_score_max) score_d = w_score_inc;
  end

  // ---------------------------------------------------------------------
  // High score. Valid BCD compares correctly as a plain binary vector
  // (MSD in the top nibble), so no per-digit compare chain is needed.
  // ---------------------------------------------------------------------
  logic [C_BW-1:0] high_q, high_d;
  logic            new_high_q, new_high_d;
  logic            new_high_prev_q, new_high_prev_d;
  logic            w_high_upd;
  logic            w_new_high_rise;

  assign w_high_upd      = score_q > high_q;
  assign w_new_high_rise = new_high_q && !new_high_prev_q;

  always_comb begin
    high_d          = w_high_upd ? score_q : high_q;
    new_high_prev_d = new_high_q;
    new_high_d      = new_high_q;
    if (i_clear)         new_high_d = 1'b0;
    else if (w_high_upd) new_high_d = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Blink FSM. half_q counts ticks inside a half-period, so the phase
  // flips whenever (BLINK_FRAMES - cnt) hits a multiple of BLINK_HALF.
  // ---------------------------------------------------------------------
  logic [0:0]          state_q, state_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [C_HALF_W-1:0] half_q, half_d;
  logic                phase_q, phase_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = 1'b1;
        if (!i_clear && w_new_high_rise) begin
          state_d = ST_BLINK;
          cnt_d   = C_CNT_W'(BLINK_FRAMES);
          half_d  = '0;
        end
      end
      ST_BLINK: begin
        if (i_clear) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          half_d  = '0;
          phase_d = 1'b1;
        end else if (i_frame_tick) begin
          if (cnt_q == C_CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            half_d  = '0;
            phase_d = 1'b1;
          end else begin
            cnt_d = cnt_q - C_CNT_W'(1);
            if (half_q == C_HALF_W'(BLINK_HALF - 1)) begin
              half_d  = '0;
              phase_d = !phase_q;
            end else begin
              half_d = half_q + C_HALF_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------
  // Returns 1 when local pixel (lx, ly) of a glyph for 'digit' is lit.
  function automatic logic seg_pixel(input logic [3:0]  digit,
                                     input logic [11:0] lx,
                                     input logic [11:0] ly);
    logic [6:0] segs;   // {a,b,c,d,e,f,g}
    logic       upper;
    logic       left;
    logic       right;
    case (digit)
      4'd0:    segs = 7'b1111110;
      4'd1:    segs = 7'b0110000;
      4'd2:    segs = 7'b1101101;
      4'd3:    segs = 7'b1111001;
      4'd4:    segs = 7'b0110011;
      4'd5:    segs = 7'b1011011;
      4'd6:    segs = 7'b1011111;
      4'd7:    segs = 7'b1110000;
      4'd8:    segs = 7'b1111111;
      4'd9:    segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase
    upper = ly < C_HALF_H;
    left  = lx < C_SEG_T;
    right = lx >= C_RIGHT_X;
    return (segs[6] && (ly < C_SEG_T))
        || (segs[5] && right && upper)
        || (segs[4] && right && !upper)
        || (segs[3] && (ly >= C_BOT_Y))
        || (segs[2] && left && !upper)
        || (segs[1] && left && upper)
        || (segs[0] && (ly >= C_MID_LO) && (ly < C_MID_HI));
  endfunction

  logic [11:0]           w_hpos_ext;
  logic [11:0]           w_vpos_ext;
  logic [11:0]           w_ly;
  logic                  w_row_in;
  logic [NUM_DIGITS-1:0] w_score_lit;
  logic [NUM_DIGITS-1:0] w_high_lit;

  assign w_hpos_ext = {2'b00, i_hpos};
  assign w_vpos_ext = {2'b00, i_vpos};
  assign w_ly       = w_vpos_ext - C_Y0;
  assign w_row_in   = (w_vpos_ext >= C_Y0) && (w_vpos_ext < C_Y0 + C_DIGIT_H);

  // Cell k is the k-th glyph from the left, i.e. k = 0 is the MSD.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam logic [11:0] C_SX0 = 12'(SCORE_X + k * C_PITCH);
    localparam logic [11:0] C_HX0 = 12'(HIGH_X + k * C_PITCH);
    localparam int          C_LSB = 4 * (NUM_DIGITS - 1 - k);
    localparam int          C_TOP = 4 * (k + 1);
    localparam bit          C_CAN_BLANK = (LEAD_BLANK != 0) && (k != NUM_DIGITS - 1);

    logic [3:0] w_s_digit;
    logic [3:0] w_h_digit;
    logic       w_s_in;
    logic       w_h_in;
    logic       w_s_blank;
    logic       w_h_blank;

    assign w_s_digit = score_q[C_LSB +: 4];
    assign w_h_digit = high_q[C_LSB +: 4];
    assign w_s_in    = w_row_in && (w_hpos_ext >= C_SX0) && (w_hpos_ext < C_SX0 + C_DIGIT_W);
    assign w_h_in    = w_row_in && (w_hpos_ext >= C_HX0) && (w_hpos_ext < C_HX0 + C_DIGIT_W);
    // Blank when this digit and every more-significant digit is zero.
    assign w_s_blank = C_CAN_BLANK && (score_q[C_BW-1 -: C_TOP] == '0);
    assign w_h_blank = C_CAN_BLANK && (high_q[C_BW-1 -: C_TOP] == '0);

    assign w_score_lit[k] = w_s_in && !w_s_blank
                          && seg_pixel(w_s_digit, w_hpos_ext - C_SX0, w_ly);
    assign w_high_lit[k]  = w_h_in && !w_h_blank
                          && seg_pixel(w_h_digit, w_hpos_ext - C_HX0, w_ly);
  end

  logic [2:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = BANNER_COLOR;
    if (w_vpos_ext >= C_BANNER_H)          rgb_d = 3'b000;
    else if ((|w_score_lit) && phase_q)    rgb_d = SCORE_COLOR;
    else if (|w_high_lit)                  rgb_d = HIGH_COLOR;
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      score_q         <= '0;
      high_q          <= '0;
      new_high_q      <= 1'b0;
      new_high_prev_q <= 1'b0;
      cnt_q           <= '0;
      half_q          <= '0;
      phase_q         <= 1'b1;
      rgb_q           <= 3'b000;
    end else begin
      score_q         <= score_d;
      high_q          <= high_d;
      new_high_q      <= new_high_d;
      new_high_prev_q <= new_high_prev_d;
      cnt_q           <= cnt_d;
      half_q          <= half_d;
      phase_q         <= phase_d;
      rgb_q           <= rgb_d;
    end
  end

  assign o_score_bcd = score_q;
  assign o_high_bcd  = high_q;
  assign o_new_high  = new_high_q;
  assign o_rgb       = rgb_q;

endmodule
`default_nettype wire

// File: doc/score_counter_display.md
Name: score_counter_display

Overview:
Parametrised score block for the top banner. It holds the running score as an N-digit BCD counter that saturates at its maximum, and it latches a high score. It renders both fields as 7-segment style glyphs in the banner region. When the high score is beaten, the score field blinks for a fixed number of frames. The 3-bit output is merged with the other layers in the top-level colour mux, where black means no draw.

Parameters:
NUM_DIGITS, 3, BCD digits per field (1..5)
BANNER_HEIGHT, 32, banner rows; output is 0 for i_vpos >= this
DIGIT_W, 12, glyph width in px
DIGIT_H, 28, glyph height in px (must be odd multiple of SEG_T; 28 with SEG_T=4 gives 7 bands)
SEG_T, 4, segment thickness in px
DIGIT_GAP, 4, px between glyphs
Y_OFFSET, 2, top row of glyphs
SCORE_X, 590, left px of score field
HIGH_X, 8, left px of high-score field
LEAD_BLANK, 1, 1 = blank leading zeros (the units digit is always drawn)
BLINK_FRAMES, 120, blink duration in frames
BLINK_HALF, 8, frames per on/off half-period
BANNER_COLOR, 3'b000, background colour
SCORE_COLOR, 3'b100, score digit colour
HIGH_COLOR, 3'b110, high-score digit colour

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  synchronous active-low reset
i_vpos  in  10  current pixel row
i_hpos  in  10  current pixel column
i_frame_tick  in  1  one-cycle pulse per frame
i_inc  in  1  one-cycle pulse: score +1
i_clear  in  1  one-cycle pulse: new game, score to 0, high score kept
o_score_bcd  out  4*NUM_DIGITS  score, BCD, units digit in [3:0]
o_high_bcd  out  4*NUM_DIGITS  high score, BCD
o_new_high  out  1  sticky: high score beaten in the current game
o_rgb  out  3  pixel colour, registered

Behaviour:
- Clock and reset: clock i_clk; reset i_rst_n, synchronous, active-low.
- Reset values: o_score_bcd=0, o_high_bcd=0, o_new_high=0, o_rgb=0, blink counter=0, blink phase=1 (visible).
- Score counter: ripple-carry BCD increment on i_inc.
  - Each digit wraps 9->0 with carry to the next digit.
  - At all-9s, i_inc is ignored (saturate; no wrap to 0).
  - i_clear has priority over i_inc in the same cycle: the score becomes 0.
  - Update is visible on o_score_bcd the cycle after the pulse.
- High score: each cycle, if o_score_bcd > o_high_bcd (BCD compare, MSD first), o_high_bcd <= o_score_bcd. This lags the score by 1 cycle.
  - Whenever that update fires, o_new_high <= 1.
  - i_clear sets o_new_high <= 0; the clear wins over a same-cycle update. Reset is the only way to clear the high score.
- Blink state machine (states IDLE, BLINK):
  - IDLE->BLINK on the rising edge of o_new_high: load cnt=BLINK_FRAMES, phase=1.
  - In BLINK, on i_frame_tick: cnt-1. Phase toggles when (BLINK_FRAMES-cnt) reaches a multiple of BLINK_HALF.
  - BLINK->IDLE when cnt reaches 0 or on i_clear; phase returns to 1.
  - A later high-score update in the same game does not retrigger the blink (o_new_high is already 1).
- Pixel path:
  - Field select: digit k of a field (k=0 is the MSD) occupies columns X+k*(DIGIT_W+DIGIT_GAP) to +DIGIT_W-1, and rows Y_OFFSET to Y_OFFSET+DIGIT_H-1.
  - Local coordinates (lx, ly) are used to decode segments a..g.
    - a: ly<SEG_T.
    - g: middle SEG_T band.
    - d: bottom SEG_T band.
    - f/b: left/right SEG_T columns in the upper half.
    - e/c: left/right SEG_T columns in the lower half.
  - Standard 7-segment map for digits 0-9. BCD codes 10-15 render blank.
  - Leading-zero blanking (LEAD_BLANK=1): digit k is blank if it and all more-significant digits are 0 and k != NUM_DIGITS-1.
  - Colour: score pixel lit and phase=1 -> SCORE_COLOR. High pixel lit -> HIGH_COLOR. Otherwise, inside the banner, BANNER_COLOR. i_vpos >= BANNER_HEIGHT -> 0.
  - Latency: o_rgb is registered, 1 clock after i_hpos/i_vpos.
  - Pixel rendering uses the current registered BCD values; no division or modulo anywhere.
- Overlapping field ranges are a parameter error; score has priority.

Test Plan:
1. Reset, then 123 i_inc pulses -> o_score_bcd=12'h123, o_high_bcd=12'h123 one cycle later, o_new_high=1.
2. Score 12'h999, i_inc -> stays 12'h999. i_inc and i_clear in the same cycle -> score 0, high unchanged, o_new_high=0.
3. Score 12'h099, i_inc -> 12'h100 (two carries in one cycle).
4. High=12'h005, new game, 6 increments -> o_new_high rises on the 6th. o_rgb at a lit score pixel alternates SCORE_COLOR/BANNER_COLOR every 8 frame ticks for 120 ticks, then stays SCORE_COLOR.
5. Score 12'h007, scan row Y_OFFSET+1 across SCORE_X.. with LEAD_BLANK=1 -> hundreds/tens cells BANNER_COLOR, segment a of the '7' is SCORE_COLOR, delayed 1 cycle. Score 0 -> only the units '0' is drawn.
6. i_vpos=BANNER_HEIGHT at any i_hpos -> o_rgb=0. i_rst_n low mid-blink -> all outputs 0 next cycle.
